serial_code_converter: RTL and testbench

Multi-digit, multi-mode 4-bit code converter that processes one digit per clock under a valid/ready handshake. It generalises the single-digit combinational BCD/Excess-3 converter to a DIGITS-wide word with four selectable codes and per-word error reporting. It sits between a digit-word producer (keypad/BCD counter path) and a display or serial-output stage.

---
 rtl/serial_code_converter_if.sv | 24 ++
 rtl/serial_code_converter.sv | 98 +++++++++
 tb/tb_serial_code_converter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_code_converter_if.sv
// Word-level handshake bundle for serial_code_converter: producer side (in_*)
// and consumer side (out_*) of one DIGITS-wide 4-bit-digit word.
interface serial_code_converter_if #(
   parameter int DIGITS = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   in_data;
   logic [1:0]            in_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_data;
   logic                  out_err;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/serial_code_converter.sv
// Converts a DIGITS-wide word one 4-bit digit per clock (BCD/XS3/Gray codes),
// flagging the word if any digit is out of range for the selected code.
module serial_code_converter #(
   parameter int DIGITS = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   serial_code_converter_if.slave bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    shift_q, shift_d;
   logic [W-1:0]    result_q, result_d;
   logic [1:0]      mode_q, mode_d;
   logic            err_q, err_d;
   logic [4:0]      conv_digit;

   // Returns {invalid, code}; an invalid digit is passed through unchanged.
   function automatic logic [4:0] convert(input logic [3:0] d, input logic [1:0] m);
      logic [4:0] r;
      r = {1'b1, d};
      case (m)
         2'b00:   if (d <= 4'd9) r = {1'b0, d + 4'd3};
         2'b01:   if ((d >= 4'd3) && (d <= 4'd12)) r = {1'b0, d - 4'd3};
         2'b10:   r = {1'b0, d ^ {1'b0, d[3:1]}};
         default: r = {1'b0, d[3], d[3] ^ d[2], d[3] ^ d[2] ^ d[1], ^d};
      endcase
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      result_d   = result_q;
      mode_d     = mode_q;
      err_d      = err_q;
      conv_digit = convert(shift_q[3:0], mode_q);

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               shift_d = bus.in_data;
               mode_d  = bus.in_mode;
               err_d   = 1'b0;
               cnt_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            // The shift register always presents the current digit at [3:0].
            for (int i = 0; i < DIGITS; i++) begin
               if (cnt_q == CW'(i)) result_d[i*4 +: 4] = conv_digit[3:0];
            end
            err_d   = err_q | conv_digit[4];
            shift_d = shift_q >> 4;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         result_q <= '0;
         mode_q   <= 2'b00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         result_q <= result_d;
         mode_q   <= mode_d;
         err_q    <= err_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = result_q;
   assign bus.out_err   = err_q;
endmodule

// File: tb/tb_serial_code_converter.sv
// Self-checking bench for serial_code_converter: directed and random words on a
// 4-digit instance, exhaustive single-digit sweep on a 1-digit instance.
module tb_serial_code_converter;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   int          lat;
   int          lastCap;
   int          nCap;
   int          nRes;
   bit          justCap;
   logic [16:0] expWord;
   logic [16:0] q[$];
   logic [15:0] rData;
   logic [1:0]  rMode;
   logic [4:0]  rDig;

   always #5 clk = ~clk;

   serial_code_converter_if #(.DIGITS(4)) bus();
   serial_code_converter_if #(.DIGITS(1)) bus1();

   serial_code_converter #(.DIGITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   serial_code_converter #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // Hard stop in case the DUT wedges somewhere the bounded waits do not cover.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: one digit, returns {invalid, code}, from the code tables.
   function automatic logic [4:0] refDigit(input int d, input int m);
      int res;
      bit bad;
      res = d;
      bad = 1'b0;
      case (m)
         0: if (d <= 9) res = (d + 3) % 16; else bad = 1'b1;
         1: if (d >= 3 && d <= 12) res = d - 3; else bad = 1'b1;
         2: res = d ^ (d >> 1);
         default: res = d ^ (d >> 1) ^ (d >> 2) ^ (d >> 3);
      endcase
      return {bad, 4'(res)};
   endfunction

   function automatic logic [16:0] refWord(input logic [15:0] w, input int m);
      logic [15:0] o;
      logic        e;
      logic [4:0]  r;
      o = '0;
      e = 1'b0;
      for (int i = 0; i < 4; i++) begin
         r = refDigit(int'(w[i*4 +: 4]), m);
         o[i*4 +: 4] = r[3:0];
         e = e | r[4];
      end
      return {e, o};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Presents a word for exactly one capture edge, then scrambles the inputs.
   task automatic applyStimulus(input logic [15:0] data, input logic [1:0] mode);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      bus.in_mode  = mode;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 16'($urandom);
      bus.in_mode  = 2'($urandom);
   endtask

   // Full word transaction on the 4-digit instance with optional back-pressure.
   task automatic runWord(input string tag, input logic [15:0] data, input logic [1:0] mode,
                          input logic [15:0] expData, input logic expErr, input int hold);
      checkOutput({tag, ":in_ready"}, 32'(bus.in_ready), 32'd1);
      applyStimulus(data, mode);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput({tag, ":latency"}, 32'(lat), 32'd4);
      checkOutput({tag, ":data"}, 32'(bus.out_data), 32'(expData));
      checkOutput({tag, ":err"}, 32'(bus.out_err), 32'(expErr));
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 16'($urandom);
         bus.in_mode  = 2'($urandom);
         @(posedge clk); #1;
         checkOutput({tag, ":hold_data"}, 32'(bus.out_data), 32'(expData));
         checkOutput({tag, ":hold_err"}, 32'(bus.out_err), 32'(expErr));
         checkOutput({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
         checkOutput({tag, ":hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, ":accept_valid"}, 32'(bus.out_valid), 32'd0);
      checkOutput({tag, ":accept_in_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_mode    = 2'b00;
      bus.out_ready  = 1'b0;
      bus1.in_valid  = 1'b0;
      bus1.in_data   = '0;
      bus1.in_mode   = 2'b00;
      bus1.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset:out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset:out_data", 32'(bus.out_data), 32'd0);
      checkOutput("reset:out_err", 32'(bus.out_err), 32'd0);
      checkOutput("reset:in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset1:out_valid", 32'(bus1.out_valid), 32'd0);
      checkOutput("reset1:in_ready", 32'(bus1.in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed words with hand-worked results.
      runWord("m00_1209", 16'h1209, 2'b00, 16'h453C, 1'b0, 0);
      runWord("m00_12A9", 16'h12A9, 2'b00, 16'h45AC, 1'b1, 0);
      runWord("m01_0000", 16'h0000, 2'b01, 16'h0000, 1'b1, 0);
      runWord("m01_453C", 16'h453C, 2'b01, 16'h1209, 1'b0, 0);
      runWord("m10_0F5A", 16'h0F5A, 2'b10, 16'h087F, 1'b0, 0);
      runWord("m11_087F", 16'h087F, 2'b11, 16'h0F5A, 1'b0, 0);

      // Back-pressure: DONE held for 3 cycles while the producer keeps pushing.
      runWord("bp", 16'h1209, 2'b00, 16'h453C, 1'b0, 3);
      checkOutput("bp:no_capture", 32'(bus.in_ready), 32'd1);

      // Back-to-back words with both handshakes held high.
      bus.in_data   = 16'($urandom);
      bus.in_mode   = 2'($urandom);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      lastCap = -1;
      nCap    = 0;
      nRes    = 0;
      justCap = 1'b0;
      for (int c = 0; c < 80 && nRes < 4; c++) begin
         if (justCap) begin
            justCap     = 1'b0;
            bus.in_data = 16'($urandom);
            bus.in_mode = 2'($urandom);
            if (nCap == 4) bus.in_valid = 1'b0;
         end
         if (bus.out_valid === 1'b1) begin
            if (q.size() > 0) begin
               expWord = q.pop_front();
               checkOutput("b2b:data", 32'(bus.out_data), 32'(expWord[15:0]));
               checkOutput("b2b:err", 32'(bus.out_err), 32'(expWord[16]));
            end
            nRes++;
         end
         if (bus.in_valid && bus.in_ready === 1'b1) begin
            if (lastCap >= 0) checkOutput("b2b:spacing", 32'(c - lastCap), 32'd6);
            lastCap = c;
            q.push_back(refWord(bus.in_data, int'(bus.in_mode)));
            nCap++;
            justCap = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checkOutput("b2b:results", 32'(nRes), 32'd4);
      checkOutput("b2b:captures", 32'(nCap), 32'd4);
      q.delete();
      @(posedge clk); #1;

      // Asynchronous reset two cycles into CONV, checked before any clock edge.
      applyStimulus(16'h12AB, 2'b00);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst:pre_err", 32'(bus.out_err), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst:out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst:out_data", 32'(bus.out_data), 32'd0);
      checkOutput("rst:out_err", 32'(bus.out_err), 32'd0);
      checkOutput("rst:in_ready", 32'(bus.in_ready), 32'd1);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      runWord("post_rst", 16'h0F5A, 2'b10, 16'h087F, 1'b0, 0);

      // Random words against the reference model.
      for (int n = 0; n < 10; n++) begin
         rData   = 16'($urandom);
         rMode   = 2'($urandom);
         expWord = refWord(rData, int'(rMode));
         runWord($sformatf("rand%0d_m%0d_%h", n, rMode, rData), rData, rMode,
                 expWord[15:0], expWord[16], int'($urandom_range(0, 2)));
      end

      // Every single digit value in every mode on the 1-digit instance.
      for (int m = 0; m < 4; m++) begin
         for (int d = 0; d < 16; d++) begin
            rDig = refDigit(d, m);
            bus1.in_valid = 1'b1;
            bus1.in_data  = 4'(d);
            bus1.in_mode  = 2'(m);
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
            bus1.in_data  = 4'($urandom);
            lat = 0;
            while (bus1.out_valid !== 1'b1 && lat < 10) begin
               @(posedge clk); #1;
               lat++;
            end
            checkOutput($sformatf("d1_m%0d_%0d:latency", m, d), 32'(lat), 32'd1);
            checkOutput($sformatf("d1_m%0d_%0d:data", m, d), 32'(bus1.out_data), 32'(rDig[3:0]));
            checkOutput($sformatf("d1_m%0d_%0d:err", m, d), 32'(bus1.out_err), 32'(rDig[4]));
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            bus1.out_ready = 1'b0;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
